// File: rtl/mult_share_sched_if.sv
// Requester and response handshake bundle for the shared-multiplier scheduler.
interface mult_share_sched_if #(
   parameter int unsigned ACC_W = 12
) ();
   logic             req0_valid;
   logic             req0_ready;
   logic [3:0]       req0_m;
   logic [3:0]       req0_q;
   logic             req0_acc;
   logic             req1_valid;
   logic             req1_ready;
   logic [3:0]       req1_m;
   logic [3:0]       req1_q;
   logic             req1_acc;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [ACC_W-1:0] rsp_result;

   modport master (
      output req0_valid, req0_m, req0_q, req0_acc,
      input  req0_ready,
      output req1_valid, req1_m, req1_q, req1_acc,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_result,
      output rsp_ready
   );

   modport slave (
      input  req0_valid, req0_m, req0_q, req0_acc,
      output req0_ready,
      input  req1_valid, req1_m, req1_q, req1_acc,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_result,
      input  rsp_ready
   );
endinterface

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one external combinational 4x4 multiplier
// between two requesters, with per-requester load/accumulate registers.
module mult_share_sched #(
   parameter int unsigned ACC_W = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   mult_share_sched_if.slave   bus,
   output logic [3:0]          mul_m,
   output logic [3:0]          mul_q,
   input  logic [7:0]          mul_p
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_gnt0;
   logic             w_gnt1;
   logic             r_ptr;
   logic             r_id;
   logic             r_acc_op;
   logic [3:0]       r_mul_m;
   logic [3:0]       r_mul_q;
   logic [ACC_W-1:0] r_acc0;
   logic [ACC_W-1:0] r_acc1;
   logic [ACC_W-1:0] r_result;
   logic [ACC_W-1:0] w_acc_sel;
   logic [ACC_W-1:0] w_sum;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and grant; r_ptr holds the last granted id, so the other side wins a tie
   always_comb begin
      w_state_nxt = r_state;
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (rst_n) begin
               if (bus.req0_valid && bus.req1_valid) begin
                  w_gnt0 = r_ptr;
                  w_gnt1 = ~r_ptr;
               end else begin
                  w_gnt0 = bus.req0_valid;
                  w_gnt1 = bus.req1_valid;
               end
            end
            if (w_gnt0 || w_gnt1) begin
               w_state_nxt = S_MUL;
            end
         end
         S_MUL: begin
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_acc_sel = r_id ? r_acc1 : r_acc0;
   assign w_sum     = r_acc_op ? (w_acc_sel + ACC_W'(mul_p)) : ACC_W'(mul_p);

   // Job capture on grant, accumulator and result update in MUL
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr    <= 1'b1;
         r_id     <= 1'b0;
         r_acc_op <= 1'b0;
         r_mul_m  <= 4'd0;
         r_mul_q  <= 4'd0;
         r_acc0   <= '0;
         r_acc1   <= '0;
         r_result <= '0;
      end else begin
         if (w_gnt0 || w_gnt1) begin
            r_ptr    <= w_gnt1;
            r_id     <= w_gnt1;
            r_acc_op <= w_gnt1 ? bus.req1_acc : bus.req0_acc;
            r_mul_m  <= w_gnt1 ? bus.req1_m : bus.req0_m;
            r_mul_q  <= w_gnt1 ? bus.req1_q : bus.req0_q;
         end
         if (r_state == S_MUL) begin
            r_result <= w_sum;
            if (r_id) begin
               r_acc1 <= w_sum;
            end else begin
               r_acc0 <= w_sum;
            end
         end
      end
   end

   assign bus.req0_ready = w_gnt0;
   assign bus.req1_ready = w_gnt1;
   assign bus.rsp_valid  = (r_state == S_RESP);
   assign bus.rsp_id     = r_id;
   assign bus.rsp_result = r_result;
   assign mul_m          = r_mul_m;
   assign mul_q          = r_mul_q;

endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: job table, scoreboard monitor and hand-written
// sequences for round-robin, back-pressure and mid-job reset.
module tb_mult_share_sched;

   localparam int unsigned ACC_W = 12;
   localparam int          MODV  = 1 << ACC_W;

   logic       clk;
   logic       rst_n;
   logic [3:0] mul_m;
   logic [3:0] mul_q;
   logic [7:0] mul_p;

   int n_cmp;
   int n_err;

   mult_share_sched_if #(.ACC_W(ACC_W)) bus ();

   mult_share_sched #(.ACC_W(ACC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .mul_m (mul_m),
      .mul_q (mul_q),
      .mul_p (mul_p)
   );

   // The shared multiplier lives outside the block
   assign mul_p = 8'(mul_m) * 8'(mul_q);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: expectations pushed on each observed grant, popped on each response
   typedef struct {
      int id;
      int res;
   } exp_t;

   exp_t sb[$];
   int   m_acc [2];
   bit   pend;
   int   pm;
   int   pq;

   task automatic model_grant(input int id, input int m, input int q, input int acc);
      exp_t e;
      int   prod;
      prod = m * q;
      m_acc[id] = (acc != 0) ? ((m_acc[id] + prod) % MODV) : prod;
      e.id  = id;
      e.res = m_acc[id];
      sb.push_back(e);
      pend = 1'b1;
      pm   = m;
      pq   = q;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         sb.delete();
         m_acc[0] = 0;
         m_acc[1] = 0;
         pend     = 1'b0;
      end else begin
         if (pend) begin
            chk("mon_mul_m", int'(mul_m), pm);
            chk("mon_mul_q", int'(mul_q), pq);
            pend = 1'b0;
         end
         if (bus.req0_ready || bus.req1_ready) begin
            chk("mon_one_ready", int'(bus.req0_ready & bus.req1_ready), 0);
         end
         if (bus.req0_valid && bus.req0_ready)
            model_grant(0, int'(bus.req0_m), int'(bus.req0_q), int'(bus.req0_acc));
         if (bus.req1_valid && bus.req1_ready)
            model_grant(1, int'(bus.req1_m), int'(bus.req1_q), int'(bus.req1_acc));
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
               chk("mon_unexpected_rsp", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("mon_rsp_id", int'(bus.rsp_id), e.id);
               chk("mon_rsp_result", int'(bus.rsp_result), e.res);
            end
         end
      end
   end

   task automatic set_req(input int id, input int v, input int m, input int q, input int acc);
      if (id == 0) begin
         bus.req0_valid = 1'(v);
         bus.req0_m     = 4'(m);
         bus.req0_q     = 4'(q);
         bus.req0_acc   = 1'(acc);
      end else begin
         bus.req1_valid = 1'(v);
         bus.req1_m     = 4'(m);
         bus.req1_q     = 4'(q);
         bus.req1_acc   = 1'(acc);
      end
   endtask

   function automatic int get_ready(input int id);
      return (id != 0) ? int'(bus.req1_ready) : int'(bus.req0_ready);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One job from an idle block with rsp_ready high; checks accept, latency and result
   task automatic run_job(input string name, input int id, input int m, input int q,
                          input int acc, input int exp, output int res);
      int cyc;
      int lat;
      bit got;
      res = -1;
      set_req(id, 1, m, q, acc);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         if (get_ready(id) != 0) got = 1'b1;
         else begin
            step();
            cyc++;
         end
      end
      chk({name, "_accept_wait"}, cyc, 0);
      step();
      set_req(id, 0, m, q, acc);
      if (!got) return;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(negedge clk);
         lat++;
         if (bus.rsp_valid) got = 1'b1;
      end
      chk({name, "_latency"}, lat, 2);
      chk({name, "_id"}, int'(bus.rsp_id), id);
      chk({name, "_result"}, int'(bus.rsp_result), exp);
      res = int'(bus.rsp_result);
      step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   typedef struct {
      int id;
      int m;
      int q;
      int acc;
      int exp;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int res;
      int cyc;
      int exp_g;
      int last;
      int ngr;
      int nrsp;
      int cnt [2];
      bit got;

      vecs[0] = '{0, 3, 5, 0, 15};
      vecs[1] = '{1, 0, 9, 1, 0};
      vecs[2] = '{1, 15, 15, 0, 225};
      vecs[3] = '{1, 15, 15, 1, 450};
      vecs[4] = '{0, 15, 15, 1, 240};
      vecs[5] = '{0, 0, 9, 0, 0};
      vecs[6] = '{1, 1, 1, 1, 180};

      n_cmp = 0;
      n_err = 0;
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      bus.rsp_ready = 1'b1;

      // Reset values
      do_reset();
      @(negedge clk);
      chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
      chk("rst_rsp_id", int'(bus.rsp_id), 0);
      chk("rst_rsp_result", int'(bus.rsp_result), 0);
      chk("rst_mul_m", int'(mul_m), 0);
      chk("rst_mul_q", int'(mul_q), 0);
      chk("rst_ready", int'(bus.req0_ready | bus.req1_ready), 0);
      step();

      // Table part 1: first job, untouched acc1, load then accumulate
      for (int i = 0; i < 4; i++)
         run_job($sformatf("vec%0d", i), vecs[i].id, vecs[i].m, vecs[i].q,
                 vecs[i].acc, vecs[i].exp, res);

      // 17 more accumulations of 225 into acc1, wrapping modulo 2^ACC_W
      for (int k = 0; k < 17; k++)
         run_job($sformatf("wrap%0d", k), 1, 15, 15, 1, ((k + 3) * 225) % MODV, res);
      chk("wrap_final", res, 179);

      // Table part 2: acc0 independent of acc1, corner operands, continue after wrap
      for (int i = 4; i < 7; i++)
         run_job($sformatf("vec%0d", i), vecs[i].id, vecs[i].m, vecs[i].q,
                 vecs[i].acc, vecs[i].exp, res);

      // Round robin: both valid through reset, 2x2 accumulate
      set_req(0, 1, 2, 2, 1);
      set_req(1, 1, 2, 2, 1);
      rst_n = 1'b0;
      step();
      @(negedge clk);
      chk("rr_ready_in_reset", int'(bus.req0_ready | bus.req1_ready), 0);
      step();
      rst_n = 1'b1;
      exp_g   = 0;
      last    = 0;
      ngr     = 0;
      nrsp    = 0;
      cnt[0]  = 0;
      cnt[1]  = 0;
      cyc     = 0;
      while (nrsp < 6 && cyc < 40) begin
         @(negedge clk);
         if (bus.req0_ready || bus.req1_ready) begin
            chk("rr_grant_id", bus.req1_ready ? 1 : 0, exp_g);
            if (ngr > 0) chk("rr_grant_gap", cyc - last, 3);
            else chk("rr_first_grant_cycle", cyc, 0);
            last  = cyc;
            exp_g = 1 - exp_g;
            ngr++;
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            chk("rr_result", int'(bus.rsp_result), 4 * (cnt[int'(bus.rsp_id)] + 1));
            cnt[int'(bus.rsp_id)]++;
            nrsp++;
         end
         step();
         cyc++;
         if (ngr == 6) begin
            set_req(0, 0, 2, 2, 1);
            set_req(1, 0, 2, 2, 1);
         end
      end
      chk("rr_responses", nrsp, 6);

      // Mid-job reset: leave pointer at 0 so only a pointer reset lets requester 0 win
      run_job("pre_mid", 0, 1, 1, 1, 13, res);
      set_req(0, 1, 2, 2, 1);
      set_req(1, 1, 2, 2, 1);
      @(negedge clk);
      chk("mid_pre_grant1", get_ready(1), 1);
      step();
      rst_n = 1'b0;
      @(negedge clk);
      step();
      @(negedge clk);
      chk("mid_rsp_valid", int'(bus.rsp_valid), 0);
      chk("mid_rsp_result", int'(bus.rsp_result), 0);
      chk("mid_ready_in_reset", int'(bus.req0_ready | bus.req1_ready), 0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_post_ready0", get_ready(0), 1);
      chk("mid_post_ready1", get_ready(1), 0);
      step();
      set_req(0, 0, 2, 2, 1);
      set_req(1, 0, 2, 2, 1);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (bus.rsp_valid) got = 1'b1;
      end
      chk("mid_post_id", int'(bus.rsp_id), 0);
      chk("mid_post_result", int'(bus.rsp_result), 4);
      step();
      run_job("acc1_cleared", 1, 1, 1, 1, 1, res);

      // Back-pressure: response held 5 cycles while requester 1 waits
      bus.rsp_ready = 1'b0;
      set_req(0, 1, 5, 3, 0);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         if (bus.req0_ready) got = 1'b1;
         else begin
            step();
            cyc++;
         end
      end
      chk("bp_accept", int'(got), 1);
      step();
      set_req(0, 0, 5, 3, 0);
      set_req(1, 1, 7, 2, 0);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (bus.rsp_valid) got = 1'b1;
         else step();
      end
      chk("bp_latency", cyc, 2);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("bp_hold_valid", int'(bus.rsp_valid), 1);
         chk("bp_hold_id", int'(bus.rsp_id), 0);
         chk("bp_hold_result", int'(bus.rsp_result), 15);
         chk("bp_hold_ready", int'(bus.req0_ready | bus.req1_ready), 0);
         step();
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", int'(bus.rsp_valid), 1);
      step();
      @(negedge clk);
      chk("bp_next_grant1", get_ready(1), 1);
      step();
      set_req(1, 0, 7, 2, 0);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (bus.rsp_valid) got = 1'b1;
      end
      chk("bp_next_result", int'(bus.rsp_result), 14);
      step();
      step();

      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
